// File: rtl/pmem_line_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : pmem_line_adaptor
// Purpose  : Bridges a cache physical-memory port (one 256-bit line per
//            request) to a 64-bit burst memory bus. Each line moves as
//            exactly four beats. Beat 0 carries line bits 63:0 and beat 3
//            carries bits 255:192.
// Revision : 1.0 - initial release
//
// Optional build macro:
//   PMEM_ADAPTOR_TIMEOUT_EN - when defined, adds a per-beat watchdog. If
//                             TIMEOUT_CYCLES cycles pass in a burst without
//                             resp_i, the transaction is aborted through DONE
//                             and error_o is set until reset. When undefined,
//                             bursts wait indefinitely and error_o is 0.
//
// Parameters:
//   TIMEOUT_CYCLES - idle cycles tolerated between beats (watchdog only)
//
// Ports:
//   clk        in   1    clock, all state changes on the rising edge
//   rst        in   1    synchronous reset, active low
//   address_i  in   32   line address from the cache
//   read_i     in   1    line read request, held until resp_o
//   write_i    in   1    line write request, held until resp_o
//   line_i     in   256  writeback line, valid while write_i is held
//   line_o     out  256  assembled fill line (line register)
//   resp_o     out  1    one-cycle completion pulse
//   error_o    out  1    sticky timeout flag
//   address_o  out  32   line-aligned burst address
//   read_o     out  1    burst read request
//   write_o    out  1    burst write request
//   burst_i    in   64   read beat data
//   burst_o    out  64   write beat data
//   resp_i     in   1    beat strobe from memory, one per beat
// ============================================================================
module pmem_line_adaptor #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  address_i,
    input  logic         read_i,
    input  logic         write_i,
    input  logic [255:0] line_i,
    output logic [255:0] line_o,
    output logic         resp_o,
    output logic         error_o,
    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    input  logic [63:0]  burst_i,
    output logic [63:0]  burst_o,
    input  logic         resp_i
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [1:0] c_LAST_BEAT = 2'd3;

    state_t         r_state;
    state_t         w_state_next;
    logic [1:0]     r_cnt;
    logic [255:0]   r_line;
    logic [31:0]    r_addr;

    logic           w_in_burst;
    logic           w_last_beat;
    logic           w_timeout;
    logic           w_error;
    logic [31:0]    w_addr_aligned;
    logic [7:0]     w_beat_base;

    assign w_in_burst     = (r_state == RD_BURST) || (r_state == WR_BURST);
    assign w_last_beat    = w_in_burst && resp_i && (r_cnt == c_LAST_BEAT);
    assign w_addr_aligned = {address_i[31:5], 5'b0};
    // Bit offset of the current beat inside the line: cnt * 64.
    assign w_beat_base    = {r_cnt, 6'd0};

`ifdef PMEM_ADAPTOR_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Watchdog: counts burst cycles since the last beat. It is held at
    // zero outside bursts, so it starts from zero on burst entry.
    // ------------------------------------------------------------------
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TO_W-1:0] r_idle_cnt;
    logic              r_error;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idle_cnt <= '0;
        end else if (!w_in_burst || resp_i) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // The TIMEOUT_CYCLES-th silent burst cycle forces the abort, so DONE
    // follows burst entry by exactly TIMEOUT_CYCLES cycles.
    assign w_timeout = w_in_burst && !resp_i &&
                       (r_idle_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_error <= 1'b0;
        end else if (w_timeout) begin
            r_error <= 1'b1;
        end
    end

    assign w_error = r_error;
`else
    // Without the watchdog TIMEOUT_CYCLES has no effect.
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_timeout        = 1'b0;
    assign w_error          = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and bus control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        read_o       = 1'b0;
        write_o      = 1'b0;
        resp_o       = 1'b0;
        case (r_state)
            IDLE: begin
                // A write wins over a simultaneous read.
                if (write_i) begin
                    w_state_next = WR_BURST;
                end else if (read_i) begin
                    w_state_next = RD_BURST;
                end
            end
            RD_BURST: begin
                read_o = 1'b1;
                if (w_last_beat || w_timeout) begin
                    w_state_next = DONE;
                end
            end
            WR_BURST: begin
                write_o = 1'b1;
                if (w_last_beat || w_timeout) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                // Unconditional return guarantees one IDLE cycle between
                // transactions while the cache withdraws its request.
                resp_o       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: address latch, beat counter and line register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= 2'd0;
            r_line <= '0;
            r_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= 2'd0;
                    if (write_i) begin
                        r_addr <= w_addr_aligned;
                        r_line <= line_i;
                    end else if (read_i) begin
                        // The line register keeps the previous fill until
                        // beats overwrite it one word at a time.
                        r_addr <= w_addr_aligned;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        r_line[w_beat_base +: 64] <= burst_i;
                        r_cnt                     <= r_cnt + 2'd1;
                    end
                end
                WR_BURST: begin
                    if (resp_i) begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign line_o    = r_line;
    assign address_o = r_addr;
    assign error_o   = w_error;
    // Write data follows the beat counter combinationally; driven low
    // outside write bursts so the bus is quiet between transactions.
    assign burst_o   = (r_state == WR_BURST) ? r_line[w_beat_base +: 64] : 64'd0;

endmodule
`default_nettype wire

// File: tb/tb_pmem_line_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmem_line_adaptor
// Purpose  : Self-checking bench for pmem_line_adaptor. Expected fill lines
//            and write beats are queued when stimulus is driven and popped
//            when the DUT presents the corresponding output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmem_line_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic         error_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic         resp_i;

    always #5 clk = ~clk;

    pmem_line_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .error_o   (error_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .resp_i    (resp_i)
    );

    int checks   = 0;
    int failures = 0;

    logic [255:0] exp_lines[$];
    logic [63:0]  exp_beats[$];
    logic [255:0] last_fill;

    // Inputs are driven and outputs sampled on the falling edge.

    task automatic test_reset;
        rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        address_i = 32'h0; line_i = '0; burst_i = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (line_o !== 256'd0) begin
            failures++;
            $display("FAIL reset_line_o: got %h expected 0", line_o);
        end
        checks++;
        if ({resp_o, error_o, read_o, write_o} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: got resp/err/rd/wr=%b expected 0000",
                     {resp_o, error_o, read_o, write_o});
        end
        checks++;
        if ({address_o, burst_o} !== 96'd0) begin
            failures++;
            $display("FAIL reset_bus: got address_o=%h burst_o=%h expected 0", address_o, burst_o);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_basic;
        logic [63:0] b[4];
        logic [255:0] exp;
        b[0] = 64'h1111_1111_1111_1111;
        b[1] = 64'h2222_2222_2222_2222;
        b[2] = 64'h3333_3333_3333_3333;
        b[3] = 64'h4444_4444_4444_4444;
        exp_lines.push_back({b[3], b[2], b[1], b[0]});
        address_i = 32'h0000_1234;
        read_i    = 1'b1;
        @(negedge clk);                         // cycle k+1
        address_i = 32'hFFFF_FFFF;              // must be ignored now
        checks++;
        if (read_o !== 1'b1 || write_o !== 1'b0) begin
            failures++;
            $display("FAIL rd_basic_req: got read_o=%b write_o=%b expected 1 0", read_o, write_o);
        end
        checks++;
        if (address_o !== 32'h0000_1220) begin
            failures++;
            $display("FAIL rd_basic_addr: got %h expected 00001220", address_o);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (resp_o !== 1'b0) begin
                failures++;
                $display("FAIL rd_basic_early_resp: got resp_o=%b at beat %0d expected 0", resp_o, i);
            end
            resp_i  = 1'b1;
            burst_i = b[i];
            @(negedge clk);
        end
        resp_i  = 1'b0;
        burst_i = '0;
        // cycle k+5
        checks++;
        if (resp_o !== 1'b1 || read_o !== 1'b0) begin
            failures++;
            $display("FAIL rd_basic_resp: got resp_o=%b read_o=%b expected 1 0", resp_o, read_o);
        end
        exp = exp_lines.pop_front();
        last_fill = exp;
        checks++;
        if (line_o !== exp) begin
            failures++;
            $display("FAIL rd_basic_line: got %h expected %h", line_o, exp);
        end
        read_i = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_o !== 1'b0) begin
            failures++;
            $display("FAIL rd_basic_resp_width: got resp_o=%b expected 0", resp_o);
        end
    endtask

    task automatic test_write;
        logic [63:0] d[4];
        logic [63:0] exp;
        d[0] = 64'hD000_0000_0000_00D0;
        d[1] = 64'hD111_1111_1111_11D1;
        d[2] = 64'hD222_2222_2222_22D2;
        d[3] = 64'hD333_3333_3333_33D3;
        for (int i = 0; i < 4; i++) exp_beats.push_back(d[i]);
        line_i    = {d[3], d[2], d[1], d[0]};
        address_i = 32'hABCD_EF7F;
        write_i   = 1'b1;
        @(negedge clk);
        line_i    = '1;                         // must be ignored now
        checks++;
        if (write_o !== 1'b1 || read_o !== 1'b0 || address_o !== 32'hABCD_EF60) begin
            failures++;
            $display("FAIL wr_req: got write_o=%b read_o=%b address_o=%h expected 1 0 abcdef60",
                     write_o, read_o, address_o);
        end
        for (int i = 0; i < 4; i++) begin
            exp = exp_beats.pop_front();
            checks++;
            if (burst_o !== exp) begin
                failures++;
                $display("FAIL wr_beat%0d: got %h expected %h", i, burst_o, exp);
            end
            resp_i = 1'b1;
            @(negedge clk);
        end
        resp_i = 1'b0;
        checks++;
        if (resp_o !== 1'b1 || write_o !== 1'b0) begin
            failures++;
            $display("FAIL wr_done: got resp_o=%b write_o=%b expected 1 0", resp_o, write_o);
        end
        write_i = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_o !== 1'b0) begin
            failures++;
            $display("FAIL wr_resp_width: got resp_o=%b expected 0", resp_o);
        end
    endtask

    task automatic test_read_gaps;
        int beat_cyc[4];
        logic [63:0] b[4];
        logic [255:0] exp;
        int idx;
        bit bad;
        beat_cyc[0] = 3; beat_cyc[1] = 7; beat_cyc[2] = 8; beat_cyc[3] = 20;
        idx = 0;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) b[i] = {$urandom, $urandom};
        exp_lines.push_back({b[3], b[2], b[1], b[0]});
        address_i = 32'h8000_0040;
        read_i    = 1'b1;
        @(negedge clk);                         // cycle 1
        for (int c = 1; c <= 20; c++) begin
            if (read_o !== 1'b1 || resp_o !== 1'b0) bad = 1'b1;
            if (idx < 4 && c == beat_cyc[idx]) begin
                resp_i  = 1'b1;
                burst_i = b[idx];
                idx++;
            end else begin
                resp_i  = 1'b0;
                burst_i = 64'hDEAD_BEEF_0BAD_F00D;
            end
            @(negedge clk);
        end
        resp_i  = 1'b0;
        burst_i = '0;
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL rd_gaps_hold: got early resp_o or dropped read_o, expected read_o=1 resp_o=0");
        end
        checks++;
        if (resp_o !== 1'b1) begin
            failures++;
            $display("FAIL rd_gaps_resp: got resp_o=%b expected 1", resp_o);
        end
        exp = exp_lines.pop_front();
        last_fill = exp;
        checks++;
        if (line_o !== exp) begin
            failures++;
            $display("FAIL rd_gaps_line: got %h expected %h", line_o, exp);
        end
        read_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_priority;
        logic [255:0] l;
        logic [63:0] exp;
        bit bad;
        bad = 1'b0;
        l = {64'hAAAA_0000_0000_0003, 64'hAAAA_0000_0000_0002,
             64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0000};
        for (int i = 0; i < 4; i++) exp_beats.push_back(l[64*i +: 64]);
        line_i    = l;
        address_i = 32'h0000_2000;
        read_i    = 1'b1;
        write_i   = 1'b1;
        @(negedge clk);
        checks++;
        if (write_o !== 1'b1 || read_o !== 1'b0) begin
            failures++;
            $display("FAIL prio_req: got write_o=%b read_o=%b expected 1 0", write_o, read_o);
        end
        for (int i = 0; i < 4; i++) begin
            exp = exp_beats.pop_front();
            if (burst_o !== exp) bad = 1'b1;
            resp_i  = 1'b1;
            burst_i = 64'h5555_5555_5555_5555;
            @(negedge clk);
        end
        resp_i  = 1'b0;
        burst_i = '0;
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL prio_beats: got wrong burst_o data, expected words of line_i");
        end
        checks++;
        if (resp_o !== 1'b1 || line_o !== l) begin
            failures++;
            $display("FAIL prio_done: got resp_o=%b line_o=%h expected 1 %h", resp_o, line_o, l);
        end
        read_i  = 1'b0;
        write_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midburst;
        logic [63:0] b[4];
        logic [255:0] exp;
        address_i = 32'h0000_0100;
        read_i    = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            resp_i  = 1'b1;
            burst_i = {$urandom, $urandom};
            @(negedge clk);
        end
        resp_i = 1'b0;
        read_i = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        checks++;
        if ({line_o, address_o, burst_o} !== 352'd0 ||
            {resp_o, error_o, read_o, write_o} !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_outputs: got line_o=%h address_o=%h burst_o=%h ctrl=%b expected all 0",
                     line_o, address_o, burst_o, {resp_o, error_o, read_o, write_o});
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) b[i] = {$urandom, $urandom};
        exp_lines.push_back({b[3], b[2], b[1], b[0]});
        address_i = 32'h0000_0ABC;
        read_i    = 1'b1;
        @(negedge clk);
        checks++;
        if (read_o !== 1'b1 || address_o !== 32'h0000_0AA0) begin
            failures++;
            $display("FAIL midrst_req: got read_o=%b address_o=%h expected 1 00000aa0", read_o, address_o);
        end
        for (int i = 0; i < 4; i++) begin
            resp_i  = 1'b1;
            burst_i = b[i];
            @(negedge clk);
        end
        resp_i = 1'b0;
        exp = exp_lines.pop_front();
        last_fill = exp;
        checks++;
        if (resp_o !== 1'b1 || line_o !== exp) begin
            failures++;
            $display("FAIL midrst_refill: got resp_o=%b line_o=%h expected 1 %h", resp_o, line_o, exp);
        end
        read_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_no_response;
        logic [63:0] b[4];
        logic [255:0] exp;
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) b[i] = {$urandom, $urandom};
        exp_lines.push_back({b[3], b[2], b[1], b[0]});
        address_i = 32'h1000_0000;
        read_i    = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 100; c++) begin
            if (resp_o !== 1'b0 || error_o !== 1'b0 || read_o !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL stall_wait: got resp_o/error_o activity or dropped read_o, expected none");
        end
        for (int i = 0; i < 4; i++) begin
            resp_i  = 1'b1;
            burst_i = b[i];
            @(negedge clk);
        end
        resp_i = 1'b0;
        exp = exp_lines.pop_front();
        last_fill = exp;
        checks++;
        if (resp_o !== 1'b1 || line_o !== exp || error_o !== 1'b0) begin
            failures++;
            $display("FAIL stall_finish: got resp_o=%b error_o=%b line_o=%h expected 1 0 %h",
                     resp_o, error_o, line_o, exp);
        end
        read_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle_ignore;
        bit bad;
        bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            resp_i  = 1'b1;
            burst_i = {$urandom, $urandom};
            @(negedge clk);
            if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0) bad = 1'b1;
        end
        resp_i = 1'b0;
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL idle_ctrl: got activity on resp_o/read_o/write_o, expected none");
        end
        checks++;
        if (line_o !== last_fill) begin
            failures++;
            $display("FAIL idle_line: got %h expected %h", line_o, last_fill);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the end of the test sequence");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read_basic();
        test_write();
        test_read_gaps();
        test_priority();
        test_reset_midburst();
        test_no_response();
        test_idle_ignore();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
